// File: rtl/i2s_capture_ctrl.sv
// i2s_capture_ctrl: host-command capture sequencer that truncates I2S samples
// and streams their top bytes MSB-first into the capture FIFO, sample-atomically.
module i2s_capture_ctrl #(
    parameter int DATA_SIZE     = 24,
    parameter int REDUCE_FACTOR = 1,
    parameter int FIFO_ADDR_W   = 19,
    parameter int BURST_SAMPLES = 48000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    input  logic [7:0]             cmd_data,
    input  logic                   sample_valid,
    input  logic [DATA_SIZE-1:0]   sample_data,
    output logic                   rx_enable,
    input  logic [FIFO_ADDR_W:0]   fifo_free,
    output logic                   fifo_wr_en,
    output logic [7:0]             fifo_wr_data,
    output logic                   fifo_clear,
    output logic                   capturing,
    output logic                   overflow,
    output logic [15:0]            drop_count,
    output logic [31:0]            sample_count
);
    localparam int KEEP_BYTES = DATA_SIZE/8 - REDUCE_FACTOR;
    localparam int KW = KEEP_BYTES*8;
    localparam int IW = KEEP_BYTES > 1 ? $clog2(KEEP_BYTES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, EMIT, FLUSH} state_t;

    state_t        state_q;
    logic [KW-1:0] buf_q;
    logic [IW-1:0] idx_q;
    logic          burst_q, stop_pending_q, cap_q, wr_en_q, clear_q, ovf_q;
    logic [31:0]   burst_left_q, cnt_q;
    logic [15:0]   drop_q;
    logic [7:0]    wr_data_q;

    logic cmd_start, cmd_stop, cmd_burst, cmd_clear, room, last_byte, burst_end, emit_drop;
    logic [15:0] drop_d;

    assign cmd_start = cmd_valid && cmd_data == 8'h01;
    assign cmd_stop  = cmd_valid && cmd_data == 8'h02;
    assign cmd_burst = cmd_valid && cmd_data == 8'h03;
    assign cmd_clear = cmd_valid && cmd_data == 8'h04;
    assign room      = fifo_free >= (FIFO_ADDR_W+1)'(KEEP_BYTES);
    assign last_byte = idx_q == IW'(KEEP_BYTES-1);
    assign drop_d    = drop_q + {15'd0, ~&drop_q};
    // Once the burst budget is spent, late samples are neither accepted nor counted
    assign emit_drop = sample_valid && !(burst_q && burst_left_q == 32'd0);
    assign burst_end = burst_q && (burst_left_q == 32'd0 || (emit_drop && burst_left_q == 32'd1));

    assign rx_enable    = cap_q;
    assign capturing    = cap_q;
    assign fifo_wr_en   = wr_en_q;
    assign fifo_wr_data = wr_data_q;
    assign fifo_clear   = clear_q;
    assign overflow     = ovf_q;
    assign drop_count   = drop_q;
    assign sample_count = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            buf_q          <= '0;
            idx_q          <= '0;
            burst_q        <= 1'b0;
            stop_pending_q <= 1'b0;
            cap_q          <= 1'b0;
            wr_en_q        <= 1'b0;
            clear_q        <= 1'b0;
            ovf_q          <= 1'b0;
            burst_left_q   <= '0;
            cnt_q          <= '0;
            drop_q         <= '0;
            wr_data_q      <= '0;
        end else begin
            wr_en_q <= 1'b0;
            clear_q <= 1'b0;
            if (cmd_clear) begin
                state_q        <= FLUSH;
                clear_q        <= 1'b1;
                cap_q          <= 1'b0;
                ovf_q          <= 1'b0;
                drop_q         <= '0;
                cnt_q          <= '0;
                stop_pending_q <= 1'b0;
                burst_q        <= 1'b0;
                burst_left_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: if (cmd_start || cmd_burst) begin
                        state_q      <= RUN;
                        cap_q        <= 1'b1;
                        burst_q      <= cmd_burst;
                        burst_left_q <= cmd_burst ? 32'(BURST_SAMPLES) : 32'd0;
                    end
                    RUN: if (cmd_stop) begin
                        state_q <= IDLE;
                        cap_q   <= 1'b0;
                    end else if (sample_valid) begin
                        if (burst_q) burst_left_q <= burst_left_q - 32'd1;
                        if (room) begin
                            state_q   <= EMIT;
                            wr_en_q   <= 1'b1;
                            wr_data_q <= sample_data[DATA_SIZE-1 -: 8];
                            buf_q     <= sample_data[DATA_SIZE-1 -: KW] << 8;
                            idx_q     <= '0;
                        end else begin
                            ovf_q  <= 1'b1;
                            drop_q <= drop_d;
                            if (burst_q && burst_left_q == 32'd1) begin
                                state_q <= IDLE;
                                cap_q   <= 1'b0;
                            end
                        end
                    end
                    EMIT: begin
                        if (cmd_stop) stop_pending_q <= 1'b1;
                        if (emit_drop) begin
                            ovf_q  <= 1'b1;
                            drop_q <= drop_d;
                            if (burst_q) burst_left_q <= burst_left_q - 32'd1;
                        end
                        if (last_byte) begin
                            cnt_q          <= cnt_q + 32'd1;
                            stop_pending_q <= 1'b0;
                            if (stop_pending_q || cmd_stop || burst_end) begin
                                state_q <= IDLE;
                                cap_q   <= 1'b0;
                            end else begin
                                state_q <= RUN;
                            end
                        end else begin
                            wr_en_q   <= 1'b1;
                            wr_data_q <= buf_q[KW-1 -: 8];
                            buf_q     <= buf_q << 8;
                            idx_q     <= idx_q + 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2s_capture_ctrl.sv
// tb_i2s_capture_ctrl: directed scenario tasks for the capture sequencer,
// with the burst length shortened to 3 samples.
module tb_i2s_capture_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [7:0]  cmd_data = 8'h00;
    logic        sample_valid = 1'b0;
    logic [23:0] sample_data = 24'h0;
    logic [19:0] fifo_free = 20'd0;
    logic        rx_enable, fifo_wr_en, fifo_clear, capturing, overflow;
    logic [7:0]  fifo_wr_data;
    logic [15:0] drop_count;
    logic [31:0] sample_count;
    int vec = 0;
    int errs = 0;
    int nbytes = 0;
    int b0;

    i2s_capture_ctrl #(.DATA_SIZE(24), .REDUCE_FACTOR(1), .FIFO_ADDR_W(19), .BURST_SAMPLES(3)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
        .sample_valid(sample_valid), .sample_data(sample_data), .rx_enable(rx_enable),
        .fifo_free(fifo_free), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
        .fifo_clear(fifo_clear), .capturing(capturing), .overflow(overflow),
        .drop_count(drop_count), .sample_count(sample_count)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (fifo_wr_en) nbytes++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [7:0] b);
        cmd_valid = 1'b1;
        cmd_data  = b;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic samp(input logic [23:0] d);
        sample_valid = 1'b1;
        sample_data  = d;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        vec++; if ({fifo_wr_en, fifo_clear, capturing, rx_enable, overflow} !== 5'b0) begin
            errs++; $display("FAIL reset_flags: got %b want 00000", {fifo_wr_en, fifo_clear, capturing, rx_enable, overflow});
        end
        vec++; if (drop_count !== 16'd0 || sample_count !== 32'd0 || fifo_wr_data !== 8'd0) begin
            errs++; $display("FAIL reset_counts: got %h/%h/%h want 0/0/0", drop_count, sample_count, fifo_wr_data);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_capture();
        cmd(8'h01);
        vec++; if (capturing !== 1'b1 || rx_enable !== 1'b1) begin
            errs++; $display("FAIL start: got cap=%b rx=%b want 1/1", capturing, rx_enable);
        end
        fifo_free = 20'd100;
        samp(24'hA1B2C3);
        vec++; if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 8'hA1) begin
            errs++; $display("FAIL cap_byte0: got %b/%h want 1/a1", fifo_wr_en, fifo_wr_data);
        end
        step();
        vec++; if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 8'hB2) begin
            errs++; $display("FAIL cap_byte1: got %b/%h want 1/b2", fifo_wr_en, fifo_wr_data);
        end
        step();
        vec++; if (fifo_wr_en !== 1'b0 || sample_count !== 32'd1 || capturing !== 1'b1) begin
            errs++; $display("FAIL cap_done: got wr=%b cnt=%0d cap=%b want 0/1/1", fifo_wr_en, sample_count, capturing);
        end
    endtask

    task automatic test_overflow();
        b0 = nbytes;
        fifo_free = 20'd1;
        samp(24'h555555);
        step();
        step();
        vec++; if (nbytes !== b0 || overflow !== 1'b1 || drop_count !== 16'd1) begin
            errs++; $display("FAIL ovf_drop: got bytes=%0d ovf=%b drops=%0d want %0d/1/1", nbytes, overflow, drop_count, b0);
        end
        fifo_free = 20'd2;
        samp(24'h123456);
        vec++; if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 8'h12) begin
            errs++; $display("FAIL ovf_byte0: got %b/%h want 1/12", fifo_wr_en, fifo_wr_data);
        end
        step();
        vec++; if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 8'h34) begin
            errs++; $display("FAIL ovf_byte1: got %b/%h want 1/34", fifo_wr_en, fifo_wr_data);
        end
        step();
        vec++; if (nbytes !== b0 + 2 || sample_count !== 32'd2) begin
            errs++; $display("FAIL ovf_accept: got bytes=%0d cnt=%0d want %0d/2", nbytes, sample_count, b0 + 2);
        end
    endtask

    task automatic test_stop_in_emit();
        fifo_free = 20'd100;
        samp(24'h778899);
        vec++; if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 8'h77) begin
            errs++; $display("FAIL stop_byte0: got %b/%h want 1/77", fifo_wr_en, fifo_wr_data);
        end
        cmd(8'h02);
        vec++; if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 8'h88 || capturing !== 1'b1) begin
            errs++; $display("FAIL stop_byte1: got %b/%h cap=%b want 1/88/1", fifo_wr_en, fifo_wr_data, capturing);
        end
        step();
        vec++; if (capturing !== 1'b0 || rx_enable !== 1'b0 || sample_count !== 32'd3) begin
            errs++; $display("FAIL stop_idle: got cap=%b rx=%b cnt=%0d want 0/0/3", capturing, rx_enable, sample_count);
        end
        b0 = nbytes;
        samp(24'h010203);
        step();
        step();
        vec++; if (nbytes !== b0) begin
            errs++; $display("FAIL stop_nowrite: got bytes=%0d want %0d", nbytes, b0);
        end
    endtask

    task automatic test_priority();
        cmd(8'h01);
        b0 = nbytes;
        cmd_valid = 1'b1;
        cmd_data = 8'h02;
        sample_valid = 1'b1;
        sample_data = 24'hFEDCBA;
        step();
        cmd_valid = 1'b0;
        sample_valid = 1'b0;
        step();
        vec++; if (capturing !== 1'b0 || drop_count !== 16'd1 || nbytes !== b0) begin
            errs++; $display("FAIL prio_stop: got cap=%b drops=%0d bytes=%0d want 0/1/%0d", capturing, drop_count, nbytes, b0);
        end
    endtask

    task automatic test_clear();
        cmd(8'h01);
        fifo_free = 20'd1;
        samp(24'h111111);
        vec++; if (drop_count !== 16'd2 || overflow !== 1'b1) begin
            errs++; $display("FAIL clr_predrop: got drops=%0d ovf=%b want 2/1", drop_count, overflow);
        end
        fifo_free = 20'd100;
        samp(24'h222222);
        cmd(8'h04);
        vec++; if (fifo_clear !== 1'b1 || fifo_wr_en !== 1'b0) begin
            errs++; $display("FAIL clr_pulse: got clr=%b wr=%b want 1/0", fifo_clear, fifo_wr_en);
        end
        vec++; if (overflow !== 1'b0 || drop_count !== 16'd0 || sample_count !== 32'd0) begin
            errs++; $display("FAIL clr_counts: got ovf=%b drops=%0d cnt=%0d want 0/0/0", overflow, drop_count, sample_count);
        end
        step();
        vec++; if (fifo_clear !== 1'b0 || capturing !== 1'b0) begin
            errs++; $display("FAIL clr_idle: got clr=%b cap=%b want 0/0", fifo_clear, capturing);
        end
    endtask

    task automatic test_burst();
        b0 = nbytes;
        fifo_free = 20'd100;
        cmd(8'h03);
        for (int i = 0; i < 5; i++) begin
            samp(24'h300000 + 24'(i));
            step();
            vec++; if (capturing !== (i < 3)) begin
                errs++; $display("FAIL burst_mid%0d: got cap=%b want %b", i, capturing, i < 3);
            end
            step();
            vec++; if (capturing !== (i < 2)) begin
                errs++; $display("FAIL burst_end%0d: got cap=%b want %b", i, capturing, i < 2);
            end
        end
        vec++; if (nbytes !== b0 + 6 || sample_count !== 32'd3) begin
            errs++; $display("FAIL burst_total: got bytes=%0d cnt=%0d want %0d/3", nbytes - b0, sample_count, 6);
        end
    endtask

    task automatic test_reset_mid_emit();
        cmd(8'h01);
        samp(24'hC0FFEE);
        #2 rst_n = 1'b0;
        #1;
        vec++; if ({fifo_wr_en, fifo_clear, capturing, rx_enable, overflow} !== 5'b0 || sample_count !== 32'd0) begin
            errs++; $display("FAIL rst_async: got %b cnt=%0d want 00000/0", {fifo_wr_en, fifo_clear, capturing, rx_enable, overflow}, sample_count);
        end
        step();
        rst_n = 1'b1;
        step();
        b0 = nbytes;
        samp(24'hABCDEF);
        step();
        step();
        vec++; if (nbytes !== b0 || capturing !== 1'b0) begin
            errs++; $display("FAIL rst_nostart: got bytes=%0d cap=%b want %0d/0", nbytes, capturing, b0);
        end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_overflow();
        test_stop_in_emit();
        test_priority();
        test_clear();
        test_burst();
        test_reset_mid_emit();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule

// File: doc/i2s_capture_ctrl.md
Name: i2s_capture_ctrl

Overview:
- Capture sequencer between the SPI command path, the I2S receiver and the byte-wide capture FIFO inside the I2S acquisition top.
- Decodes one-byte host commands: START, STOP, BURST, CLEAR.
- Gates the I2S receiver and truncates each DATA_SIZE-bit sample to its most-significant KEEP_BYTES bytes, where KEEP_BYTES = DATA_SIZE/8 - REDUCE_FACTOR.
- Writes those bytes MSB-first into the FIFO. Writes are sample-atomic: a sample is either written in full or dropped and counted.

Parameters:
- DATA_SIZE, 24, sample width from the I2S receiver; must be a multiple of 8.
- REDUCE_FACTOR, 1, number of LSB bytes discarded per sample; requires DATA_SIZE/8 - REDUCE_FACTOR >= 1.
- FIFO_ADDR_W, 19, width of the FIFO free-space count.
- BURST_SAMPLES, 48000, number of samples captured by the BURST command.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  one-cycle strobe: a host command byte was received
- cmd_data  in  8  command byte: 0x01 START, 0x02 STOP, 0x03 BURST, 0x04 CLEAR; all other values ignored
- sample_valid  in  1  one-cycle strobe: new I2S sample available
- sample_data  in  DATA_SIZE  I2S sample, two's complement
- rx_enable  out  1  enables the I2S receiver and clock generator
- fifo_free  in  FIFO_ADDR_W+1  free byte slots in the FIFO, registered
- fifo_wr_en  out  1  FIFO write strobe
- fifo_wr_data  out  8  FIFO write byte
- fifo_clear  out  1  one-cycle FIFO flush pulse
- capturing  out  1  high in RUN and EMIT states
- overflow  out  1  sticky: at least one sample dropped since the last CLEAR
- drop_count  out  16  dropped samples, saturates at 0xFFFF
- sample_count  out  32  samples written to the FIFO, wraps

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-low. Every register is cleared on reset; all outputs are 0 and the state is IDLE. Reset during EMIT abandons the sample. Any partially written sample already in the FIFO is the host's responsibility (host issues CLEAR).
- States: IDLE, RUN, EMIT, FLUSH.
- IDLE:
  - START → RUN with burst_mode = 0.
  - BURST → RUN with burst_mode = 1 and burst_left = BURST_SAMPLES.
  - CLEAR → FLUSH.
  - STOP → ignored.
- RUN, on sample_valid:
  - If fifo_free >= KEEP_BYTES: latch the top KEEP_BYTES bytes of sample_data, set byte index = 0, go to EMIT.
  - Otherwise: drop the sample, set overflow, increment drop_count (saturating), stay in RUN.
  - In burst mode, every sample_valid seen in RUN (accepted or dropped) decrements burst_left. When burst_left reaches 0, the state goes to IDLE after the current sample completes (immediately, if the sample was dropped).
- EMIT:
  - fifo_wr_en = 1 for exactly KEEP_BYTES consecutive cycles.
  - fifo_wr_data = sample bits [DATA_SIZE-1 -: 8], then the next lower byte, and so on.
  - Latency: sample_valid in cycle N gives the first fifo_wr_en in cycle N+1.
  - After the last byte: sample_count += 1, then go to RUN, or to IDLE if a stop is pending or the burst is done.
  - sample_valid during EMIT: drop, overflow = 1, drop_count += 1. Counts toward the burst.
- Commands in RUN/EMIT:
  - STOP in RUN → IDLE next cycle.
  - STOP in EMIT → sets stop_pending. The current sample completes, then IDLE.
  - START or BURST while capturing → ignored, with no counter reload.
  - CLEAR in any state → FLUSH immediately, aborting any EMIT in progress.
- FLUSH: fifo_clear = 1 for one cycle. overflow, drop_count, sample_count, stop_pending and burst state are cleared. Next state is IDLE.
- rx_enable = capturing, registered with the state. In IDLE and FLUSH, sample_valid is ignored and not counted.
- Simultaneous cmd_valid and sample_valid in RUN: the command takes priority. STOP or CLEAR discards the sample without counting it as dropped.
- Simultaneous sample_valid and completion of the final burst sample: the new sample is not accepted and is not counted.

Test Plan:
- Reset with START, then sample 0xA1B2C3 with fifo_free = 100 → fifo_wr_en for 2 cycles starting the next cycle, data 0xA1 then 0xB2; sample_count = 1; capturing = 1.
- In RUN with fifo_free = 1, send a sample → no write; overflow = 1; drop_count = 1. Set fifo_free = 2 and send the next sample → 2 bytes written.
- BURST with BURST_SAMPLES overridden to 3, then 5 samples → exactly 6 bytes written; capturing falls after the 3rd sample's last byte; sample_count = 3.
- STOP issued in the same cycle as the first EMIT byte → both bytes written, then IDLE. A later sample produces no write.
- CLEAR during EMIT after a prior drop → one-cycle fifo_clear pulse; overflow, drop_count and sample_count = 0; IDLE.
- rst_n asserted mid-EMIT → all outputs 0 asynchronously; after release, a sample with no START produces no write.
